// File: rtl/icache_pkg.sv
// Shared types and address-split helpers for the instruction cache.
//   icache_state_t : refill controller states
//   NOP            : instruction returned while the cache is stalling (addi x0,x0,0)
//   off_width / idx_width / tag_width : derive the byte-offset, index and tag
//   field widths from the cache geometry parameters.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    REFILL
  } icache_state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  function automatic int off_width(input int words_per_line);
    return $clog2(words_per_line) + 2;
  endfunction

  function automatic int idx_width(input int num_sets);
    return $clog2(num_sets);
  endfunction

  function automatic int tag_width(input int addr_width, input int num_sets,
                                   input int words_per_line);
    return addr_width - idx_width(num_sets) - off_width(words_per_line);
  endfunction

endpackage

// File: rtl/icache_responder_if.sv
// Fetch-side lookup and backing-memory refill signals of the instruction cache.
//   flush_i, addr_i          : fetch -> cache (invalidate-all, PCF byte address)
//   instr_o, stall_o         : cache -> fetch (instruction, hold-PC request)
//   mem_req_o, mem_addr_o    : cache -> memory (line refill request)
//   mem_req_ready_i          : memory -> cache (request accepted)
//   mem_data_valid_i/data_i  : memory -> cache (refill beats, word 0 first)
// Modports: slave = the cache, master = fetch stage plus backing memory.
interface icache_responder_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  flush_i;
  logic [ADDR_WIDTH-1:0] addr_i;
  logic [DATA_WIDTH-1:0] instr_o;
  logic                  stall_o;
  logic                  mem_req_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic                  mem_req_ready_i;
  logic                  mem_data_valid_i;
  logic [DATA_WIDTH-1:0] mem_data_i;

  modport slave (
    input  flush_i, addr_i, mem_req_ready_i, mem_data_valid_i, mem_data_i,
    output instr_o, stall_o, mem_req_o, mem_addr_o
  );

  modport master (
    output flush_i, addr_i, mem_req_ready_i, mem_data_valid_i, mem_data_i,
    input  instr_o, stall_o, mem_req_o, mem_addr_o
  );
endinterface

// File: rtl/icache_data_array.sv
// Word storage for the instruction cache: NUM_SETS lines of WORDS_PER_LINE words.
//   clk                      : clock
//   rd_set, rd_word, rd_data : asynchronous read port
//   we, wr_set, wr_word, wr_data : synchronous single-word write port
// Contents are not reset; the tag/valid arrays decide what may be read out.
module icache_data_array #(
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_SETS       = 64,
  parameter int WORDS_PER_LINE = 4,
  localparam int IDX_W  = $clog2(NUM_SETS),
  localparam int WSEL_W = $clog2(WORDS_PER_LINE)
) (
  input  logic                  clk,
  input  logic [IDX_W-1:0]      rd_set,
  input  logic [WSEL_W-1:0]     rd_word,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  we,
  input  logic [IDX_W-1:0]      wr_set,
  input  logic [WSEL_W-1:0]     wr_word,
  input  logic [DATA_WIDTH-1:0] wr_data
);

  logic [DATA_WIDTH-1:0] mem_q [NUM_SETS][WORDS_PER_LINE];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[wr_set][wr_word] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_set][rd_word];

endmodule

// File: rtl/icache_responder.sv
// Direct-mapped instruction cache between the fetch stage and backing memory.
//   clk, rst : clock, synchronous active-high reset
//   bus      : icache_responder_if slave (lookup, stall, refill handshake)
// Hits return the word combinationally; a miss stalls fetch while one line is
// requested and streamed in beat by beat, then the lookup is retried.
module icache_responder
  import icache_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int NUM_SETS       = 64,
  parameter int WORDS_PER_LINE = 4
) (
  input logic              clk,
  input logic              rst,
  icache_responder_if.slave bus
);

  localparam int OFF_W  = off_width(WORDS_PER_LINE);
  localparam int IDX_W  = idx_width(NUM_SETS);
  localparam int TAG_W  = tag_width(ADDR_WIDTH, NUM_SETS, WORDS_PER_LINE);
  localparam int WSEL_W = OFF_W - 2;

  icache_state_t         state_q, state_d;
  logic [NUM_SETS-1:0]   valid_q;
  logic [TAG_W-1:0]      tag_q [NUM_SETS];
  logic [ADDR_WIDTH-1:0] miss_addr_q;
  logic [WSEL_W-1:0]     beat_cnt_q;
  logic                  flush_pend_q;

  logic [IDX_W-1:0]      addr_idx, miss_idx;
  logic [TAG_W-1:0]      addr_tag, miss_tag;
  logic [WSEL_W-1:0]     addr_word;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  hit, stall, beat_last, data_we;
  logic                  addr_unused;

  assign addr_idx    = bus.addr_i[OFF_W +: IDX_W];
  assign addr_tag    = bus.addr_i[ADDR_WIDTH-1 -: TAG_W];
  assign addr_word   = bus.addr_i[OFF_W-1:2];
  assign addr_unused = ^bus.addr_i[1:0];
  assign miss_idx    = miss_addr_q[OFF_W +: IDX_W];
  assign miss_tag    = miss_addr_q[ADDR_WIDTH-1 -: TAG_W];

  assign hit       = valid_q[addr_idx] && (tag_q[addr_idx] == addr_tag);
  assign stall     = (state_q != IDLE) || !hit;
  assign beat_last = (beat_cnt_q == WSEL_W'(WORDS_PER_LINE - 1));
  assign data_we   = (state_q == REFILL) && bus.mem_data_valid_i;

  icache_data_array #(
    .DATA_WIDTH    (DATA_WIDTH),
    .NUM_SETS      (NUM_SETS),
    .WORDS_PER_LINE(WORDS_PER_LINE)
  ) u_data (
    .clk    (clk),
    .rd_set (addr_idx),
    .rd_word(addr_word),
    .rd_data(rd_data),
    .we     (data_we),
    .wr_set (miss_idx),
    .wr_word(beat_cnt_q),
    .wr_data(bus.mem_data_i)
  );

  assign bus.stall_o    = stall;
  assign bus.instr_o    = stall ? DATA_WIDTH'(NOP) : rd_data;
  assign bus.mem_req_o  = (state_q == REQ);
  assign bus.mem_addr_o = (state_q == REQ) ? miss_addr_q : '0;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!hit) state_d = REQ;
      REQ:     if (bus.mem_req_ready_i) state_d = REFILL;
      REFILL:  if (bus.mem_data_valid_i && beat_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      miss_addr_q  <= '0;
      beat_cnt_q   <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (bus.flush_i) valid_q <= '0;
          if (!hit) begin
            miss_addr_q <= {bus.addr_i[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
            beat_cnt_q  <= '0;
          end
        end
        REQ: begin
          if (bus.flush_i) flush_pend_q <= 1'b1;
          // Drop the old line before any beat overwrites it, so a partially
          // refilled set can never produce a hit.
          if (bus.mem_req_ready_i) begin
            valid_q[miss_idx] <= 1'b0;
            beat_cnt_q        <= '0;
          end
        end
        REFILL: begin
          if (bus.flush_i) flush_pend_q <= 1'b1;
          if (bus.mem_data_valid_i) begin
            beat_cnt_q <= beat_cnt_q + 1'b1;
            if (beat_last) begin
              tag_q[miss_idx] <= miss_tag;
              // A flush seen at any point of the refill (including this
              // final beat) wins over validating the new line.
              if (flush_pend_q || bus.flush_i) valid_q <= '0;
              else                             valid_q[miss_idx] <= 1'b1;
              flush_pend_q <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_responder.sv
module tb_icache_responder;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  icache_responder_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  icache_responder #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_SETS(64), .WORDS_PER_LINE(4)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- backing memory ----------------
  logic [31:0] ovr [logic [31:0]];
  function automatic logic [31:0] bmem(input logic [31:0] a);
    if (ovr.exists(a)) return ovr[a];
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  // ---------------- behavioural cache model ----------------
  // Lines are identified by their full line address; a refill is one
  // outstanding transaction (request phase, then beats).
  bit          m_valid [64];
  logic [31:0] m_line  [64];
  logic [31:0] m_data  [64][4];
  bit          m_busy, m_req, m_pend;
  logic [31:0] m_addr;
  int          m_beats;

  function automatic bit e_hit();
    int s;
    s = int'(bus.addr_i[9:4]);
    return !m_busy && m_valid[s] && (m_line[s] == {bus.addr_i[31:4], 4'h0});
  endfunction

  initial begin
    m_busy = 0; m_req = 0; m_pend = 0; m_beats = 0; m_addr = '0;
    foreach (m_valid[i]) m_valid[i] = 0;
  end

  always @(posedge clk) begin
    int s;
    bit h;
    h = e_hit();
    s = int'(m_addr[9:4]);
    if (rst) begin
      m_busy = 0; m_req = 0; m_pend = 0;
      foreach (m_valid[i]) m_valid[i] = 0;
    end else if (!m_busy) begin
      if (bus.flush_i) foreach (m_valid[i]) m_valid[i] = 0;
      if (!h) begin
        m_busy = 1; m_req = 1; m_pend = 0; m_beats = 0;
        m_addr = {bus.addr_i[31:4], 4'h0};
      end
    end else if (m_req) begin
      if (bus.flush_i) m_pend = 1;
      if (bus.mem_req_ready_i) begin
        m_req = 0;
        m_valid[s] = 0;
      end
    end else begin
      if (bus.flush_i) m_pend = 1;
      if (bus.mem_data_valid_i) begin
        m_data[s][m_beats] = bus.mem_data_i;
        m_beats++;
        if (m_beats == 4) begin
          m_busy = 0;
          if (m_pend) foreach (m_valid[i]) m_valid[i] = 0;
          else begin
            m_valid[s] = 1;
            m_line[s]  = m_addr;
          end
          m_pend = 0;
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    bit h;
    h = e_hit();
    chk("stall", 32'(bus.stall_o), 32'(!h));
    chk("instr", bus.instr_o, h ? m_data[bus.addr_i[9:4]][bus.addr_i[3:2]] : NOP);
    chk("mem_req", 32'(bus.mem_req_o), 32'(m_busy && m_req));
    chk("mem_addr", bus.mem_addr_o, (m_busy && m_req) ? m_addr : 32'h0);
  end

  // ---------------- memory-side driver ----------------
  bit auto_mem;
  int ready_lat;  // <0: random acceptance, else cycles held low in REQ
  int gap_mode;   // 0: back-to-back, 1: alternate gaps, 2: random gaps
  int req_cycles;
  bit gap_t;
  bit stray;

  task automatic drive_mem();
    bit v;
    if (m_busy && m_req) begin
      bus.mem_req_ready_i = (ready_lat < 0) ? ($urandom_range(0, 2) == 0)
                                            : (req_cycles >= ready_lat);
      req_cycles++;
    end else begin
      bus.mem_req_ready_i = 1'($urandom_range(0, 1));
      req_cycles = 0;
    end
    if (m_busy && !m_req) begin
      if (gap_mode == 0)      v = 1;
      else if (gap_mode == 1) begin v = gap_t; gap_t = !gap_t; end
      else                    v = 1'($urandom_range(0, 1));
      bus.mem_data_valid_i = v;
      bus.mem_data_i = v ? bmem(m_addr + 32'(4 * m_beats)) : $urandom;
    end else begin
      gap_t = 1;
      bus.mem_data_valid_i = stray && ($urandom_range(0, 3) == 0);
      bus.mem_data_i = $urandom;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (auto_mem) drive_mem();
  endtask

  task automatic wait_fill(input string name, output logic [31:0] req_addr);
    int n;
    bit got;
    n = 0; got = 0; req_addr = '0;
    do begin
      tick();
      if (bus.mem_req_o && !got) begin
        req_addr = bus.mem_addr_o;
        got = 1;
      end
      n++;
    end while (bus.stall_o && n < 300);
    if (bus.stall_o) chk({name, "_timeout"}, 32'(bus.stall_o), 32'h0);
  endtask

  task automatic wait_refill_of(input string name, input logic [31:0] line);
    int n;
    n = 0;
    while (!(m_busy && !m_req && m_addr == line) && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) chk({name, "_timeout"}, 32'h1, 32'h0);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (m_busy && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) chk({name, "_timeout"}, 32'h1, 32'h0);
  endtask

  initial begin
    logic [31:0] ra;
    rst = 1'b1;
    bus.flush_i = 0; bus.addr_i = 32'h0000_0104;
    bus.mem_req_ready_i = 0; bus.mem_data_valid_i = 0; bus.mem_data_i = '0;
    auto_mem = 0; ready_lat = -1; gap_mode = 2; req_cycles = 0; gap_t = 1; stray = 0;
    for (int i = 0; i < 4; i++) ovr[32'h100 + 32'(4 * i)] = 32'hA0 + 32'(i);

    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_stall", 32'(bus.stall_o), 32'h1);
    chk("rst_req", 32'(bus.mem_req_o), 32'h0);
    chk("rst_addr", bus.mem_addr_o, 32'h0);
    chk("rst_instr", bus.instr_o, NOP);

    // Cold miss, immediate accept, back-to-back beats
    tick(); #1;
    chk("cold_req", 32'(bus.mem_req_o), 32'h1);
    chk("cold_addr", bus.mem_addr_o, 32'h0000_0100);
    bus.mem_req_ready_i = 1;
    tick();
    bus.mem_req_ready_i = 0;
    #1 chk("cold_req_once", 32'(bus.mem_req_o), 32'h0);
    for (int i = 0; i < 4; i++) begin
      bus.mem_data_valid_i = 1;
      bus.mem_data_i = 32'hA0 + 32'(i);
      #1 chk("cold_stall_fill", 32'(bus.stall_o), 32'h1);
      tick();
    end
    bus.mem_data_valid_i = 0;
    #1;
    chk("cold_hit_stall", 32'(bus.stall_o), 32'h0);
    chk("cold_hit_instr", bus.instr_o, 32'hA1);

    // Hit sweep
    for (int i = 0; i < 4; i++) begin
      bus.addr_i = 32'h100 + 32'(4 * i);
      #1;
      chk("sweep_stall", 32'(bus.stall_o), 32'h0);
      chk("sweep_instr", bus.instr_o, 32'hA0 + 32'(i));
      chk("sweep_req", 32'(bus.mem_req_o), 32'h0);
      tick();
    end

    // Conflict eviction
    auto_mem = 1; stray = 1; drive_mem();
    bus.addr_i = 32'h500;
    wait_fill("conf500", ra);
    chk("conf_addr500", ra, 32'h500);
    bus.addr_i = 32'h100;
    #1 chk("conf_remiss", 32'(bus.stall_o), 32'h1);
    wait_fill("conf100", ra);
    chk("conf_addr100", ra, 32'h100);
    chk("conf_instr", bus.instr_o, 32'hA0);

    // Back-pressure and gapped beats
    ready_lat = 3; gap_mode = 1;
    bus.addr_i = 32'h30C;
    wait_fill("bp", ra);
    chk("bp_addr", ra, 32'h300);
    chk("bp_instr", bus.instr_o, bmem(32'h30C));
    ready_lat = -1; gap_mode = 2;

    // Flush during refill: line must not validate
    bus.addr_i = 32'h900;
    wait_refill_of("flush_wait", 32'h900);
    bus.flush_i = 1;
    tick();
    bus.flush_i = 0;
    wait_done("flush_done");
    #1 chk("flush_noval", 32'(bus.stall_o), 32'h1);
    bus.addr_i = 32'h100;
    #1 chk("flush_100_miss", 32'(bus.stall_o), 32'h1);

    // Redirect mid-refill
    wait_refill_of("redir_wait", 32'h100);
    bus.addr_i = 32'h200;
    wait_done("redir_done");
    wait_fill("redir200", ra);
    chk("redir_addr", ra, 32'h200);
    bus.addr_i = 32'h104;
    #1;
    chk("redir_100_valid", 32'(bus.stall_o), 32'h0);
    chk("redir_100_instr", bus.instr_o, 32'hA1);

    // Reset mid-refill
    bus.addr_i = 32'h400;
    wait_refill_of("rstm_wait", 32'h400);
    rst = 1;
    tick();
    rst = 0;
    #1;
    chk("rstm_req", 32'(bus.mem_req_o), 32'h0);
    chk("rstm_stall", 32'(bus.stall_o), 32'h1);
    tick(); #1;
    chk("rstm_rereq", 32'(bus.mem_req_o), 32'h1);
    chk("rstm_readdr", bus.mem_addr_o, 32'h400);
    wait_fill("rstm_fill", ra);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      bus.flush_i = ($urandom_range(0, 49) == 0);
      rst = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 2) == 0)
        bus.addr_i = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 3)) << 4)
                   | 32'($urandom_range(0, 15));
      tick();
    end
    bus.flush_i = 0; rst = 0;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
